keypad_scanner: RTL

- Drives the rows of the 4x4 matrix keypad and samples its columns.
- Synchronizes and debounces key presses and enforces one key at a time.
- Emits a one-cycle strobe with the pressed key's one-hot `{col,row}` code.
- Sits between the keypad pins and the key-code-to-hex decoder, producing exactly the 8-bit code that decoder consumes.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_sync.sv | 34 +++
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   scan_state_t : scanner FSM states (SCAN, DEBOUNCE, HELD, RELEASE)
//   KP_ROWS/COLS : keypad geometry
//   key_code_t   : 8-bit {col, row} code, both fields one-hot active-high
//   is_onehot    : true when exactly one column bit is set
//   row_onehot   : one-hot row select for a 2-bit row index
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [KP_COLS-1:0] col;
    logic [KP_ROWS-1:0] row;
  } key_code_t;

  function automatic logic is_onehot(input logic [KP_COLS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [KP_ROWS-1:0] row_onehot(input logic [1:0] r);
    return {{(KP_ROWS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad column inputs. Both stages
// reset to 1, i.e. "no column pulled low".
// Ports:
//   clk   : system clock
//   reset : synchronous, active-low reset
//   d     : asynchronous column pins
//   q     : synchronized columns (two cycles of latency)
// -----------------------------------------------------------------------------
module keypad_sync
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [KP_COLS-1:0] d,
  output logic [KP_COLS-1:0] q
);

  logic [KP_COLS-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; with blocking, q would see d directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one row at a time, debounces a single pressed key
// and reports it as a one-hot {col,row} code with a one-cycle strobe.
// Parameters:
//   SCAN_DIV        : cycles each row is driven before the columns are sampled
//   DEBOUNCE_CYCLES : consecutive stable cycles required for press and release
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-low reset
//   cols        : keypad columns, active-low, asynchronous
//   rows        : keypad row drive, active-low one-cold
//   key_code    : last accepted key, {col[3:0], row[3:0]} one-hot
//   key_valid   : one-cycle pulse when a new key is accepted
//   key_held    : high while the accepted key is held (through release debounce)
//   key_release : one-cycle pulse when key_held falls; only present when the
//                 KEYPAD_RELEASE_EN macro is defined
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 2000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   cols,
  output logic [3:0]   rows,
  output logic [7:0]   key_code,
  output logic         key_valid,
  output logic         key_held
`ifdef KEYPAD_RELEASE_EN
  ,
  output logic         key_release
`endif
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  logic [KP_COLS-1:0] cols_sync;
  logic [KP_COLS-1:0] cs;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cols_sync)
  );

  assign cs = ~cols_sync;

  scan_state_t        state_q, state_n;
  logic [1:0]         row_q, row_n;
  logic [KP_ROWS-1:0] rows_q, rows_n;
  logic [DW-1:0]      dwell_q, dwell_n;
  logic [BW-1:0]      db_q, db_n;
  logic [KP_ROWS-1:0] prow_q, prow_n;
  logic [KP_COLS-1:0] pcol_q, pcol_n;
  key_code_t          code_q, code_n;
  logic               valid_q, valid_n;
  logic               held_q, held_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      rows_q  <= 4'b1110;
      dwell_q <= '0;
      db_q    <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      rows_q  <= rows_n;
      dwell_q <= dwell_n;
      db_q    <= db_n;
      prow_q  <= prow_n;
      pcol_q  <= pcol_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      held_q  <= held_n;
    end
  end

  always_comb begin
    // NOTE: every variable of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_n = state_q;
    row_n   = row_q;
    dwell_n = '0;          // dwell only runs in SCAN; any exit leaves it cleared
    db_n    = db_q;
    prow_n  = prow_q;
    pcol_n  = pcol_q;
    code_n  = code_q;
    valid_n = 1'b0;
    held_n  = held_q;

    case (state_q)
      SCAN: begin
        // Columns are only trusted at the end of the dwell, once the newly
        // driven row has settled through the synchronizer.
        if (dwell_q == DWELL_LAST) begin
          if (is_onehot(cs)) begin
            prow_n  = row_onehot(row_q);
            pcol_n  = cs;
            db_n    = '0;
            state_n = DEBOUNCE;
          end else begin
            row_n = row_q + 2'd1;
          end
        end else begin
          dwell_n = dwell_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (cs != pcol_q) begin
          row_n   = row_q + 2'd1;
          state_n = SCAN;
        end else if (db_q == DB_LAST) begin
          code_n  = '{col: pcol_q, row: prow_q};
          valid_n = 1'b1;
          held_n  = 1'b1;
          state_n = HELD;
        end else begin
          db_n = db_q + 1'b1;
        end
      end

      HELD: begin
        // Only the accepted column matters; other keys on this row are ignored.
        if ((cs & pcol_q) == '0) begin
          db_n    = '0;
          state_n = RELEASE;
        end
      end

      RELEASE: begin
        if ((cs & pcol_q) != '0) begin
          state_n = HELD;
        end else if (db_q == DB_LAST) begin
          held_n  = 1'b0;
          row_n   = row_q + 2'd1;
          state_n = SCAN;
        end else begin
          db_n = db_q + 1'b1;
        end
      end

      default: state_n = SCAN;
    endcase

    rows_n = ~row_onehot(row_n);
  end

  assign rows      = rows_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

`ifdef KEYPAD_RELEASE_EN
  // The release strobe is exactly the falling edge of key_held, registered in
  // the same cycle so the two stay aligned.
  logic rel_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= held_q & ~held_n;
    end
  end

  assign key_release = rel_q;
`endif

endmodule
